wb_cmd_master: RTL

- Wishbone B4 classic-cycle initiator. It drives the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_we_i/wb_sel_i, answered by wb_ack_o).
- Takes buffered read/write commands from a simple valid/ready command port and issues one single-transfer cycle per command.
- Returns read data or an error on a response pulse.
- Holds all traffic until the SDRAM controller reports sdr_init_done.

---
 rtl/wb_cmd_master.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone B4 classic-cycle initiator for the SDRAM controller's slave port.
// Read/write commands arrive on a valid/ready port and are buffered in a small
// FIFO. Each command becomes exactly one single-transfer Wishbone cycle, and
// its outcome is returned as a one-clock response pulse. No cycle is launched
// until the SDRAM controller reports sdr_init_done.
//
// Handshake semantics (command port): a command is transferred on every
// rising edge where cmd_valid && cmd_ready; cmd_ready is simply "FIFO not
// full" and never depends on cmd_valid. The response port has no
// back-pressure: rsp_valid is a single-cycle pulse that must be consumed.
//
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a cycle that has
// not been acknowledged within TIMEOUT_CYCLES clocks (rsp_err=1). Without the
// macro the master waits for ack indefinitely and rsp_err is tied to 0.
//
// Ports:
//   wb_clk_i, wb_resetn        clock, asynchronous active-low reset
//   sdr_init_done              SDRAM init complete (level)
//   cmd_valid/cmd_ready        command handshake
//   cmd_we/addr/wdata/sel      command payload
//   rsp_valid/rsp_rdata/rsp_err  response pulse, read data, timeout flag
//   wb_cyc_o .. wb_sel_o       registered Wishbone initiator outputs
//   wb_dat_i, wb_ack_i         Wishbone slave returns
//   busy                       FIFO non-empty or a cycle in progress
//   dbg_state                  FSM state (IDLE=0, BUS=1, DONE=2)
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int AW             = 26,
    parameter int DW             = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_resetn,
    input  logic              sdr_init_done,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [DW/8-1:0]   cmd_sel,

    output logic              rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,

    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(CMD_DEPTH);   // FIFO index width
    localparam int PW = IW + 1;              // pointer width incl. wrap bit
    localparam int EW = 1 + AW + DW + SW;    // packed entry {we, addr, data, sel}

    // Elaboration-time parameter sanity checks.
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_cmd_master: CMD_DEPTH must be a power of two >= 2");
    end
    if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
        $error("wb_cmd_master: DW must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic [EW-1:0] mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr_q[IW-1:0]];

    // Storage carries no reset: entries are only read when the pointers say
    // they were written.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_q[IW-1:0]] <= {cmd_we, cmd_addr, cmd_wdata, cmd_sel};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Cycle FSM
    // -----------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic            cyc_d;
    logic            stb_d;
    logic            we_d;
    logic [AW-1:0]   adr_d;
    logic [DW-1:0]   dat_d;
    logic [SW-1:0]   sel_d;
    logic            rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_d;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;
    logic          rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cyc_d       = wb_cyc_o;
        stb_d       = wb_stb_o;
        we_d        = wb_we_o;
        adr_d       = wb_adr_o;
        dat_d       = wb_dat_o;
        sel_d       = wb_sel_o;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        rsp_err_d   = rsp_err;
`endif

        case (state_q)
            IDLE: begin
                if (!empty && sdr_init_done) begin
                    pop     = 1'b1;
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    {we_d, adr_d, dat_d, sel_d} = head;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end

            BUS: begin
                // Address/data/control stay untouched until ack so the slave
                // sees a stable request for the whole cycle.
                if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wb_we_o ? '0 : wb_dat_i;
                    state_d     = DONE;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    // Ack has priority above; this only fires on a silent slave.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    to_cnt_d    = to_cnt_q + TW'(1);
`endif
                end
            end

            DONE: begin
                // One forced idle clock between cycles.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q   <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            wb_cyc_o  <= cyc_d;
            wb_stb_o  <= stb_d;
            wb_we_o   <= we_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            wb_sel_o  <= sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            to_cnt_q <= '0;
            rsp_err  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            rsp_err  <= rsp_err_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign busy      = !empty || (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
